// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-prefixed, big-endian byte image into
// instruction memory and holds the CPU in reset until it is loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA, FLUSH, CHK, DONE, ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t      state, next_state;
  logic        armed;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_next;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic        accept;
  logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xsum;
`endif

  // armed keeps the port closed for the first cycle out of reset
  assign rx_ready  = armed && (state == LEN_HI || state == LEN_LO ||
                               state == DATA   || state == CHK);
  assign accept    = rx_valid && rx_ready;
  assign len_next  = {len_hi, rx_data};
  assign last_word = (words_loaded + 16'd1) == len;

  always_ff @(posedge clock) begin
    if (reset) state <= LEN_HI;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cpu_reset  = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      LEN_HI: if (accept) next_state = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_next} > MAX_WORDS) begin
            next_state = ERROR;
          end else if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            next_state = CHK;
`else
            next_state = DONE;
`endif
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        // FLUSH lets the final write land before the CPU leaves reset
        if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = FLUSH;
`endif
        end
      end
      FLUSH: next_state = DONE;
      CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) next_state = (rx_data == xsum) ? DONE : ERROR;
`else
        next_state = ERROR;
`endif
      end
      DONE: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      ERROR: load_error = 1'b1;
      default: next_state = LEN_HI;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      armed        <= 1'b0;
      len_hi       <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      partial      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          LEN_HI: len_hi <= rx_data;
          LEN_LO: len    <= len_next;
          DATA: begin
            partial  <= {partial[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {partial, rx_data};
              imem_addr    <= words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // running XOR over every accepted frame byte; compared in CHK
  always_ff @(posedge clock) begin
    if (reset)       xsum <= '0;
    else if (accept) xsum <= xsum ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: self-checking bench for imem_boot_loader, covering the
// plain build and the IMEM_LOADER_CHECKSUM_EN build.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;
  logic [15:0]       words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] len;
    int          gap;
    bit          bad_chk;
    bit          exp_err;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ready_drops = 0;
  int          frame_words = 0;
  bit          expect_we = 1'b0;
  bit          chk_done_next = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] frame_w[$];
  vec_t        vecs[$];

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Write monitor: every write must follow a 4th data byte by one cycle and
  // match the next word the reference model predicted.
  always @(negedge clock) begin
    logic [31:0] a, d;
    if (chk_done_next) begin
      chk_done_next = 1'b0;
      check_output("release_after_last_write", {30'd0, load_done, cpu_reset}, 32'd2);
    end
    if (imem_we || expect_we) begin
      check_output("write_latency", {31'd0, imem_we}, {31'd0, expect_we});
      expect_we = 1'b0;
      if (imem_we) begin
        if (exp_addr_q.size() == 0) begin
          check_output("spurious_write", 32'd1, 32'd0);
        end else begin
          a = exp_addr_q.pop_front();
          d = exp_data_q.pop_front();
          check_output("write_addr", {24'd0, imem_addr}, a);
          check_output("write_data", imem_wdata, d);
          check_output("words_loaded_at_write", {16'd0, words_loaded}, a + 1);
          check_output("cpu_reset_during_write", {31'd0, cpu_reset}, 32'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
          if (int'(a) == frame_words - 1) chk_done_next = 1'b1;
`endif
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input int gap, input bit word_end);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    if (!rx_ready) ready_drops++;
    while (!rx_ready && t < 64) begin
      @(negedge clock);
      t++;
    end
    if (!rx_ready) begin
      check_output("byte_accept_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clock);
    if (word_end) expect_we = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rx_valid = 1'b0;
    expect_we = 1'b0;
    chk_done_next = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clock);
    check_output("cpu_reset_in_reset", {31'd0, cpu_reset}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    check_output("reset_flags", {27'd0, rx_ready, imem_we, cpu_reset, load_done, load_error},
                 32'b00100);
    check_output("reset_data", {imem_addr, imem_wdata[7:0], words_loaded},
                 {8'd0, 8'd0, 16'd0});
    check_output("reset_wdata", imem_wdata, 32'd0);
    @(negedge clock);
    check_output("ready_after_first_cycle", {31'd0, rx_ready}, 32'd1);
  endtask

  // Reference: N words follow a 2-byte length unless N exceeds the memory,
  // each word goes to index i, and the checksum is the XOR of all frame bytes.
  task automatic run_frame(input logic [15:0] len, input int gap, input bit bad_chk,
                           input bit exp_err, input bit fixed);
    logic [7:0] b[$];
    logic [7:0] xs;
    bit len_bad;
    do_reset();
    len_bad = int'(len) > (1 << ADDR_W);
    if (!fixed) begin
      frame_w.delete();
      if (!len_bad) for (int i = 0; i < int'(len); i++) frame_w.push_back($urandom);
    end
    frame_words = len_bad ? 0 : int'(len);
    ready_drops = 0;
    b.push_back(len[15:8]);
    b.push_back(len[7:0]);
    if (!len_bad) begin
      for (int i = 0; i < int'(len); i++) begin
        for (int k = 3; k >= 0; k--) b.push_back(8'(frame_w[i] >> (8 * k)));
        exp_addr_q.push_back(i);
        exp_data_q.push_back(frame_w[i]);
      end
    end
    xs = 8'd0;
    foreach (b[i]) xs = xs ^ b[i];
    for (int i = 0; i < b.size(); i++)
      apply_stimulus(b[i], gap, (i >= 2) && ((i - 2) % 4 == 3));
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!len_bad) apply_stimulus(bad_chk ? ~xs : xs, gap, 1'b0);
`endif
    repeat (3) @(negedge clock);
    check_output("no_ready_drop", ready_drops, 32'd0);
    check_output("final_flags", {29'd0, load_error, load_done, cpu_reset},
                 {29'd0, exp_err, !exp_err, exp_err});
    check_output("final_ready", {31'd0, rx_ready}, 32'd0);
    check_output("final_words", {16'd0, words_loaded}, len_bad ? 32'd0 : 32'(len));
    check_output("writes_outstanding", exp_addr_q.size(), 32'd0);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) @(negedge clock);
    check_output("stray_not_accepted", {30'd0, rx_ready, load_done}, {30'd0, 1'b0, !exp_err});
    check_output("stray_words", {16'd0, words_loaded}, len_bad ? 32'd0 : 32'(len));
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] part[6];
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    vecs.push_back('{16'd0,      0, 1'b0, 1'b0});
    vecs.push_back('{16'h0101,   0, 1'b0, 1'b1});
    vecs.push_back('{16'hFFFF,   1, 1'b0, 1'b1});
    vecs.push_back('{16'd1,      2, 1'b0, 1'b0});
    vecs.push_back('{16'd5,      $urandom_range(0, 2), 1'b0, 1'b0});
    vecs.push_back('{16'd256,    0, 1'b0, 1'b0});
    vecs.push_back('{16'd3,      $urandom_range(0, 3), 1'b0, 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back('{16'd4,      1, 1'b1, 1'b1});
    vecs.push_back('{16'd0,      0, 1'b1, 1'b1});
`endif

    frame_w = '{32'h20080005, 32'h01095020};
    run_frame(16'd2, 0, 1'b0, 1'b0, 1'b1);
    run_frame(16'd2, 3, 1'b0, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_frame(16'd2, 0, 1'b1, 1'b1, 1'b1);
`endif

    // Partial load interrupted by reset, then the full image resent
    do_reset();
    part = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    frame_words = 2;
    exp_addr_q.push_back(0);
    exp_data_q.push_back(32'h20080005);
    for (int i = 0; i < 6; i++) apply_stimulus(part[i], 0, i == 5);
    @(negedge clock);
    check_output("partial_write_seen", exp_addr_q.size(), 32'd0);
    check_output("partial_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    run_frame(16'd2, 0, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i]) run_frame(vecs[i].len, vecs[i].gap, vecs[i].bad_chk, vecs[i].exp_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
